ball_motion_2d: RTL and testbench
=================================

# ball_motion_2d

Parametrised two-axis ball motion engine for the pong playfield: replaces the single-axis x mover with x and y position, wall reflection, paddle-hit handshake, goal detection and a serve state machine. Sits between the game-control logic, which supplies serve, speed and paddle hits, and the ball renderer, which consumes `x_pos`/`y_pos` on the pixel clock domain.

## Interface
- `POS_W`, 12, position width in bits
- `X_MIN`, 0, left playfield edge (pixels)
- `X_MAX`, 1023, right playfield edge
- `Y_MIN`, 0, top edge
- `Y_MAX`, 767, bottom edge
- `RADIUS`, 10, ball half-size; edge tests use centre ± RADIUS
- `X_START`, 512, serve x position
- `Y_START`, 384, serve y position
- `TICK_DIV`, 800_000, pclk cycles per motion step (≥2)
- `WALL_X`, 0, 1 = left/right edges reflect (demo mode); 0 = left/right edges are goals

- `pclk` in 1 system/pixel clock
- `reset` in 1 synchronous, active-high
- `serve` in 1 single-cycle pulse; launches ball from SERVE
- `speed` in 4 pixels moved per axis per step; 0 freezes motion, tick counter keeps running
- `hit_left` in 1 pulse: left paddle overlaps ball
- `hit_right` in 1 pulse: right paddle overlaps ball
- `x_pos` out POS_W ball centre x
- `y_pos` out POS_W ball centre y
- `running` out 1 high in RUN
- `miss_left` out 1 one-cycle pulse: ball passed left goal
- `miss_right` out 1 one-cycle pulse: ball passed right goal

## Operation
- States: SERVE (hold at start position), RUN (moving), MISS (one-cycle pulse state).
- SERVE → RUN on `serve`; tick counter reloads to TICK_DIV-1 on that edge. `serve` ignored outside SERVE.
- RUN: counter decrements each cycle; when counter = 0 a step occurs and counter reloads.
- Step, x axis: candidate = x ± speed per `dx`. Moving right and candidate + RADIUS ≥ X_MAX: if WALL_X, x = X_MAX - RADIUS, dx flips; else → MISS with `miss_right`. Left edge symmetric (candidate - RADIUS ≤ X_MIN, clamp X_MIN + RADIUS). Compare in POS_W+2 bits signed; no wrap-around.
- Step, y axis: same test against Y_MIN/Y_MAX; always reflects, clamps, flips `dy`.
- Paddle hits: `hit_left`/`hit_right` set sticky flags; flags cleared at every step and in SERVE/MISS. At a step, left flag with dx = left (resp. right flag with dx = right) flips dx before the candidate is formed; hit on the wrong-direction side is ignored. Hit beats goal on the same step.
- MISS: pulse output for the MISS cycle, x/y reload X_START/Y_START, dx set pointing away from the missed side, dy kept; next state SERVE.
- Reset values: state SERVE, x_pos = X_START, y_pos = Y_START, dx = right, dy = down, counter = TICK_DIV-1, flags 0, `running` 0, `miss_*` 0. Reset in any state, including mid-step, wins.

## Timing
- All outputs registered; position updates the edge after counter = 0 (step every TICK_DIV cycles in RUN, first step TICK_DIV cycles after the `serve` edge).
- `running` rises the cycle after the `serve` edge; falls the cycle MISS is entered.
- `miss_*` high exactly one cycle, coincident with x_pos/y_pos returning to start; state SERVE the following cycle.
- Hit pulse on the same cycle as counter = 0 is honoured at that step.
- Speed sampled only at the step cycle.

## Structure
- Shared package `pong_pkg`: state encoding (SERVE/RUN/MISS), direction constants, default playfield geometry (1024×768, RADIUS) reused by paddle and renderer blocks.
- One sub-module: `ball_axis` — one axis step/clamp/reflect unit (pos, dir, speed, min, max, radius, reflect enable → next pos, next dir, edge_hit), instantiated for x and y.

## Test plan
- TICK_DIV=4, speed=1, reset then `serve`: x=512→513 and y=384→385 every 4 cycles; `running`=1 one cycle after serve.
- y at 756, dy down, speed=2: next step y=757 clamp (757+10=767), dy flips; following step y=755.
- WALL_X=0, x at 1012 moving right, speed=1, no hit: `miss_right` one cycle, x=512, y=384, dx = left, state SERVE, `running`=0.
- Same as above with `hit_right` pulsed 2 cycles before the step: no miss, x=1011, dx = left; `hit_left` in same setup ignored.
- speed=0 in RUN for 3 ticks: x/y unchanged; speed=3 then moves 3 px per step.
- Assert `reset` mid-RUN on a counter=0 cycle: next cycle x=512, y=384, state SERVE, all pulses 0; subsequent `serve` restarts normally.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: ball state encoding, direction constants and the
// default playfield geometry used by the ball, paddle and renderer blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    RUN   = 2'd1,
    MISS  = 2'd2
  } ball_state_e;

  // Positive direction is right on x and down on y.
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam int FIELD_W     = 1024;
  localparam int FIELD_H     = 768;
  localparam int BALL_RADIUS = 10;

endpackage

// File: rtl/ball_motion_2d_if.sv
// Game-control side of the ball engine: serve/speed/paddle hits in,
// ball position, run status and goal pulses out.
interface ball_motion_2d_if #(
  parameter int POS_W = 12
);
  logic             serve;
  logic [3:0]       speed;
  logic             hit_left;
  logic             hit_right;
  logic [POS_W-1:0] x_pos;
  logic [POS_W-1:0] y_pos;
  logic             running;
  logic             miss_left;
  logic             miss_right;

  modport master (
    output serve, speed, hit_left, hit_right,
    input  x_pos, y_pos, running, miss_left, miss_right
  );

  modport slave (
    input  serve, speed, hit_left, hit_right,
    output x_pos, y_pos, running, miss_left, miss_right
  );
endinterface

// File: rtl/ball_motion_2d_axis.sv
// One axis of ball motion: forms the candidate position, detects an edge
// crossing (centre +/- RADIUS) and optionally clamps and reflects.
module ball_axis
  import pong_pkg::*;
#(
  parameter int POS_W   = 12,
  parameter int MIN     = 0,
  parameter int MAX     = FIELD_W - 1,
  parameter int RADIUS  = BALL_RADIUS,
  parameter bit REFLECT = 1'b1
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic             dir_i,
  input  logic [3:0]       speed_i,
  output logic [POS_W-1:0] pos_o,
  output logic             dir_o,
  output logic             edge_hit_o
);
  localparam int W = POS_W + 2;
  localparam logic signed [W-1:0] MIN_S = W'(MIN);
  localparam logic signed [W-1:0] MAX_S = W'(MAX);
  localparam logic signed [W-1:0] RAD_S = W'(RADIUS);

  logic signed [W-1:0] pos_s;
  logic signed [W-1:0] spd_s;
  logic signed [W-1:0] cand_s;

  // Two guard bits keep the candidate from wrapping past either edge.
  always_comb begin
    pos_s      = signed'({2'b00, pos_i});
    spd_s      = signed'(W'(speed_i));
    cand_s     = (dir_i == DIR_POS) ? pos_s + spd_s : pos_s - spd_s;
    pos_o      = cand_s[POS_W-1:0];
    dir_o      = dir_i;
    edge_hit_o = 1'b0;
    if ((dir_i == DIR_POS) && (cand_s + RAD_S >= MAX_S)) begin
      edge_hit_o = 1'b1;
      if (REFLECT) begin
        pos_o = POS_W'(MAX - RADIUS);
        dir_o = DIR_NEG;
      end
    end else if ((dir_i == DIR_NEG) && (cand_s - RAD_S <= MIN_S)) begin
      edge_hit_o = 1'b1;
      if (REFLECT) begin
        pos_o = POS_W'(MIN + RADIUS);
        dir_o = DIR_POS;
      end
    end
  end
endmodule

// File: rtl/ball_motion_2d.sv
// Two-axis pong ball engine: serve state machine, step tick divider, paddle
// hit latching, wall reflection and goal detection.
module ball_motion_2d
  import pong_pkg::*;
#(
  parameter int POS_W    = 12,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = FIELD_W - 1,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = FIELD_H - 1,
  parameter int RADIUS   = BALL_RADIUS,
  parameter int X_START  = FIELD_W / 2,
  parameter int Y_START  = FIELD_H / 2,
  parameter int TICK_DIV = 800_000,
  parameter bit WALL_X   = 1'b0
) (
  input logic             pclk,
  input logic             reset,
  ball_motion_2d_if.slave bus
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TICK_DIV - 1);

  ball_state_e      state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             dx_q, dx_d, dy_q, dy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hitl_q, hitl_d, hitr_q, hitr_d;
  logic             running_q, running_d;
  logic             miss_l_q, miss_l_d, miss_r_q, miss_r_d;

  logic             hitl_now, hitr_now, dx_eff;
  logic [POS_W-1:0] x_nx, y_nx;
  logic             dx_nx, dy_nx, x_edge, y_edge_unused;

  // A pulse arriving on the step cycle itself still counts for that step.
  assign hitl_now = hitl_q | bus.hit_left;
  assign hitr_now = hitr_q | bus.hit_right;
  assign dx_eff   = ((hitl_now && dx_q == DIR_NEG) || (hitr_now && dx_q == DIR_POS)) ? ~dx_q : dx_q;

  ball_axis #(
    .POS_W(POS_W), .MIN(X_MIN), .MAX(X_MAX), .RADIUS(RADIUS), .REFLECT(WALL_X)
  ) u_axis_x (
    .pos_i(x_q), .dir_i(dx_eff), .speed_i(bus.speed),
    .pos_o(x_nx), .dir_o(dx_nx), .edge_hit_o(x_edge)
  );

  ball_axis #(
    .POS_W(POS_W), .MIN(Y_MIN), .MAX(Y_MAX), .RADIUS(RADIUS), .REFLECT(1'b1)
  ) u_axis_y (
    .pos_i(y_q), .dir_i(dy_q), .speed_i(bus.speed),
    .pos_o(y_nx), .dir_o(dy_nx), .edge_hit_o(y_edge_unused)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;
    hitl_d   = 1'b0;
    hitr_d   = 1'b0;
    miss_l_d = 1'b0;
    miss_r_d = 1'b0;
    case (state_q)
      SERVE: begin
        cnt_d = CNT_RELOAD;
        if (bus.serve) state_d = RUN;
      end
      RUN: begin
        hitl_d = hitl_now;
        hitr_d = hitr_now;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d  = CNT_RELOAD;
          hitl_d = 1'b0;
          hitr_d = 1'b0;
          if (x_edge && !WALL_X) begin
            // Goal: re-centre and aim away from the side that missed.
            state_d = MISS;
            x_d     = POS_W'(X_START);
            y_d     = POS_W'(Y_START);
            if (dx_eff == DIR_POS) begin
              miss_r_d = 1'b1;
              dx_d     = DIR_NEG;
            end else begin
              miss_l_d = 1'b1;
              dx_d     = DIR_POS;
            end
          end else begin
            x_d  = x_nx;
            dx_d = dx_nx;
            y_d  = y_nx;
            dy_d = dy_nx;
          end
        end
      end
      MISS: begin
        state_d = SERVE;
        cnt_d   = CNT_RELOAD;
      end
      default: state_d = SERVE;
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= SERVE;
      x_q       <= POS_W'(X_START);
      y_q       <= POS_W'(Y_START);
      dx_q      <= DIR_POS;
      dy_q      <= DIR_POS;
      cnt_q     <= CNT_RELOAD;
      hitl_q    <= 1'b0;
      hitr_q    <= 1'b0;
      running_q <= 1'b0;
      miss_l_q  <= 1'b0;
      miss_r_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      cnt_q     <= cnt_d;
      hitl_q    <= hitl_d;
      hitr_q    <= hitr_d;
      running_q <= running_d;
      miss_l_q  <= miss_l_d;
      miss_r_q  <= miss_r_d;
    end
  end

  assign bus.x_pos      = x_q;
  assign bus.y_pos      = y_q;
  assign bus.running    = running_q;
  assign bus.miss_left  = miss_l_q;
  assign bus.miss_right = miss_r_q;
endmodule

// File: tb/tb_ball_motion_2d.sv
// Scoreboard bench for ball_motion_2d: the driver queues cycle-stamped
// expected outputs, a negedge monitor pops and compares them.
module tb_ball_motion_2d;
  import pong_pkg::*;

  localparam int TD = 4;

  logic pclk = 1'b0;
  logic reset;
  always #5 pclk = ~pclk;

  ball_motion_2d_if #(.POS_W(12)) bus ();

  ball_motion_2d #(
    .POS_W(12), .TICK_DIV(TD), .WALL_X(1'b0)
  ) dut (
    .pclk(pclk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [63:0] nm;
    int          x;
    int          y;
    logic        run;
    logic        ml;
    logic        mr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   finish_req = 1'b0;
  bit   drain_done = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    exp_t e;
    if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc || bus.x_pos !== 12'(e.x) || bus.y_pos !== 12'(e.y) ||
          bus.running !== e.run || bus.miss_left !== e.ml || bus.miss_right !== e.mr) begin
        bad++;
        $display("FAIL %s cyc=%0d/%0d: got x=%0d y=%0d run=%b ml=%b mr=%b, want x=%0d y=%0d run=%b ml=%b mr=%b",
                 e.nm, cyc, e.cyc, bus.x_pos, bus.y_pos, bus.running, bus.miss_left, bus.miss_right,
                 e.x, e.y, e.run, e.ml, e.mr);
      end else begin
        $display("ok   %s cyc=%0d: x=%0d y=%0d run=%b ml=%b mr=%b",
                 e.nm, cyc, bus.x_pos, bus.y_pos, bus.running, bus.miss_left, bus.miss_right);
      end
    end
    if (finish_req && !drain_done) begin
      drain_done = 1'b1;
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
    end
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge pclk);
  endtask

  task automatic expect_at(input int c, input logic [63:0] nm, input int x, input int y,
                           input logic r, input logic ml, input logic mr);
    exp_t e;
    e.cyc = c; e.nm = nm; e.x = x; e.y = y; e.run = r; e.ml = ml; e.mr = mr;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, s2, s3;
    bus.serve = 1'b0; bus.speed = 4'd1; bus.hit_left = 1'b0; bus.hit_right = 1'b0;
    reset = 1'b1;
    @(negedge pclk);
    expect_at(cyc + 1, "reset", 512, 384, 0, 0, 0);
    at(3); reset = 1'b0;
    expect_at(cyc + 1, "idle", 512, 384, 0, 0, 0);

    // Serve at speed 1: one pixel per axis every TD cycles.
    at(5); bus.serve = 1'b1; s = cyc + 1;
    expect_at(s,     "run_up",   512, 384, 1, 0, 0);
    expect_at(s + 3, "pre_step", 512, 384, 1, 0, 0);
    expect_at(s + 4, "step1",    513, 385, 1, 0, 0);
    expect_at(s + 8, "step2",    514, 386, 1, 0, 0);
    @(negedge pclk); bus.serve = 1'b0;

    // Frozen for three steps, then 3 px per step.
    at(s + 8); bus.speed = 4'd0;
    expect_at(s + 12, "spd0_a", 514, 386, 1, 0, 0);
    expect_at(s + 16, "spd0_b", 514, 386, 1, 0, 0);
    expect_at(s + 20, "spd0_c", 514, 386, 1, 0, 0);
    at(s + 20); bus.speed = 4'd3;
    expect_at(s + 24, "spd3_a", 517, 389, 1, 0, 0);
    expect_at(s + 28, "spd3_b", 520, 392, 1, 0, 0);

    // Bottom wall: 26 steps of 14 to y=756, then speed 2 clamps at 757.
    at(s + 28); bus.speed = 4'd14;
    expect_at(s + 132, "y756", 884, 756, 1, 0, 0);
    at(s + 132); bus.speed = 4'd2;
    expect_at(s + 136, "yclamp", 886, 757, 1, 0, 0);
    expect_at(s + 140, "yback", 888, 755, 1, 0, 0);

    // Drive x to 1012 moving right.
    at(s + 140); bus.speed = 4'd15;
    expect_at(s + 172, "x1008", 1008, 635, 1, 0, 0);
    at(s + 172); bus.speed = 4'd4;
    expect_at(s + 176, "x1012", 1012, 631, 1, 0, 0);

    // Wrong-side left hit is ignored: right goal.
    at(s + 176); bus.speed = 4'd1;
    expect_at(s + 180, "miss_r", 512, 384, 0, 0, 1);
    expect_at(s + 181, "serve_a", 512, 384, 0, 0, 0);
    expect_at(s + 183, "serve_b", 512, 384, 0, 0, 0);
    at(s + 177); bus.hit_left = 1'b1;
    at(s + 178); bus.hit_left = 1'b0;

    // Re-serve heads left (dy kept up); left hit on the step cycle turns it right.
    at(s + 184); bus.serve = 1'b1; s2 = cyc + 1;
    expect_at(s2,     "serve2", 512, 384, 1, 0, 0);
    expect_at(s2 + 4, "hitl_ok", 513, 383, 1, 0, 0);
    @(negedge pclk); bus.serve = 1'b0;
    at(s2 + 3); bus.hit_left = 1'b1;
    at(s2 + 4); bus.hit_left = 1'b0; bus.speed = 4'd15;
    expect_at(s2 + 104, "ytop", 888, 10, 1, 0, 0);
    expect_at(s2 + 136, "x1008b", 1008, 130, 1, 0, 0);
    at(s2 + 136); bus.speed = 4'd4;
    expect_at(s2 + 140, "x1012b", 1012, 134, 1, 0, 0);

    // Right paddle hit two cycles before the step beats the goal.
    at(s2 + 140); bus.speed = 4'd1;
    expect_at(s2 + 144, "hitr_ok", 1011, 135, 1, 0, 0);
    expect_at(s2 + 148, "after_h", 1010, 136, 1, 0, 0);
    at(s2 + 141); bus.hit_right = 1'b1;
    at(s2 + 142); bus.hit_right = 1'b0;

    // Reset on a counter=0 cycle wins over the step.
    at(s2 + 151); reset = 1'b1;
    expect_at(s2 + 152, "rst_mid", 512, 384, 0, 0, 0);
    expect_at(s2 + 153, "rst_hold", 512, 384, 0, 0, 0);
    at(s2 + 152); reset = 1'b0;
    at(s2 + 153); bus.serve = 1'b1; s3 = cyc + 1;
    expect_at(s3,     "serve3", 512, 384, 1, 0, 0);
    expect_at(s3 + 4, "s3_st1", 513, 385, 1, 0, 0);
    expect_at(s3 + 8, "s3_st2", 514, 386, 1, 0, 0);
    @(negedge pclk); bus.serve = 1'b0;

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge pclk);
    finish_req = 1'b1;
    repeat (2) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
